board_input_reader: RTL and testbench
=====================================

BOARD_INPUT_READER -- requirements
Module: board_input_reader

Interface
REQ-001 Parameter N_IN, default 4: number of board push-button/switch inputs, range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-level cycles required before accepting a change (10 ms at 100 MHz), minimum 2.
REQ-003 Port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1: reset; synchronous and active-high.
REQ-005 Port raw_in  input  N_IN: asynchronous, bouncing board inputs, active-high.
REQ-006 Port rd_en  input  1: one-cycle read strobe from the CPU side.
REQ-007 Port rd_addr  input  2: register select for the read.
REQ-008 Port rd_data  output  32: registered read data.
REQ-009 Port rd_valid  output  1: high exactly one cycle per accepted read.
REQ-010 Port irq  output  1: pending-event interrupt; present only under BOARD_INPUT_IRQ_EN.

Function
REQ-011 Each raw_in bit SHALL pass a 2-flop synchronizer before any other use.
REQ-012 Per bit, a debounce counter SHALL clear whenever the synchronized value equals the accepted level, and SHALL otherwise increment.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while the mismatch persists, the accepted level SHALL take the synchronized value on the next edge and the counter SHALL clear.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL never change the accepted level.
REQ-015 A 0->1 transition of an accepted level SHALL set that bit's pending flag; 1->0 transitions SHALL NOT set it.
REQ-016 A 32-bit press counter SHALL add the number of bits with a 0->1 accepted transition in that cycle.
REQ-017 The press counter SHALL wrap from 0xFFFFFFFF to 0, without a flag.
REQ-018 A read SHALL be accepted every cycle rd_en is high; rd_data and rd_valid SHALL update on the next edge (latency 1), so back-to-back reads are legal.
REQ-019 Read map: addr 0 = accepted levels, zero-extended; addr 1 = pending flags, zero-extended; addr 2 = press counter; addr 3 = 0.
REQ-020 Reading addr 1 SHALL clear all pending flags returned.
REQ-021 A new rising event on a bit in the same cycle as an addr 1 read SHALL leave that bit set after the clear (event wins).
REQ-022 rd_data SHALL hold its last value while rd_valid is low.

Reset
REQ-023 On rst high at a clock edge: synchronizers, accepted levels, debounce counters, pending flags, press counter, rd_data, rd_valid and irq SHALL all become 0.
REQ-024 Reset SHALL take priority over all other activity, including rd_en in the same cycle.
REQ-025 Assertion mid-debounce SHALL discard partial counts; inputs already high at release SHALL count as one press after DEBOUNCE_CYCLES plus sync delay.

Configuration
REQ-026 With macro BOARD_INPUT_IRQ_EN defined, irq SHALL be a registered OR of the pending flags: high one cycle after any flag sets, low one cycle after the clearing read.
REQ-027 Without BOARD_INPUT_IRQ_EN, the irq port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package board_io_pkg SHALL hold the read-address constants (ADDR_LEVEL=0, ADDR_PEND=1, ADDR_COUNT=2), DATA_W=32 and the default N_IN.
REQ-029 Sub-module input_debouncer SHALL hold one bit's synchronizer, counter and accepted level, and SHALL output level and rise_pulse; it SHALL be instantiated N_IN times.

Verification (DEBOUNCE_CYCLES=4, N_IN=4)
REQ-030 raw_in[0] high for 3 cycles, then low -> addr 0 reads 0x0, addr 2 reads 0.
REQ-031 raw_in[2] held high 10 cycles -> addr 0 = 0x4, addr 1 = 0x4, second addr 1 read = 0x0, addr 2 = 1.
REQ-032 raw_in bits 0 and 1 rise together and are held -> addr 2 increments by 2 in one cycle; addr 1 = 0x3.
REQ-033 addr 1 read issued in the same cycle as bit 3's rise_pulse -> returns the old flags, and a following read returns 0x8.
REQ-034 Press counter preloaded by force to 0xFFFFFFFF, then one press -> addr 2 = 0x0.
REQ-035 rst asserted mid-debounce with rd_en=1 -> rd_valid=0 and all registers 0; with BOARD_INPUT_IRQ_EN, irq rises 1 cycle after a pending flag sets and falls 1 cycle after the clearing read.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants for the board input reader.
// Read map: ADDR_LEVEL = accepted levels, ADDR_PEND = pending rise flags
// (clear on read), ADDR_COUNT = 32-bit press counter; address 3 reads zero.
package board_io_pkg;

    localparam int DATA_W       = 32;
    localparam int N_IN_DEFAULT = 4;

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_PEND  = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;

    // Number of set bits; sized for the widest allowed input vector.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// One board input: 2-flop synchronizer, debounce counter and accepted level.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   raw         - asynchronous bouncing input
//   level       - accepted (debounced) level
//   rise_pulse  - high in the cycle before level goes 0->1, so the owner can
//                 register the event on the same edge that level rises
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          sync;
    logic          settle;

    assign sync       = sync_q[1];
    // Mismatch has lasted DEBOUNCE_CYCLES cycles including this one.
    assign settle     = (sync != level) && (cnt == LAST);
    assign rise_pulse = settle && sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/board_input_reader.sv
// Debounced board button/switch reader with a small read-only register file.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   raw_in[N_IN]      - asynchronous bouncing inputs, active-high
//   rd_en, rd_addr    - one-cycle read strobe and register select
//   rd_data, rd_valid - registered read response, latency 1
//   irq               - OR of pending flags, only with BOARD_INPUT_IRQ_EN
// Optional feature macro: BOARD_INPUT_IRQ_EN (adds the irq port/register).
module board_input_reader
    import board_io_pkg::*;
#(
    parameter int N_IN            = N_IN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   raw_in,
    input  logic              rd_en,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
`ifdef BOARD_INPUT_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [N_IN-1:0]   level;
    logic [N_IN-1:0]   rise;
    logic [N_IN-1:0]   pend;
    logic [DATA_W-1:0] press_cnt;
    logic [DATA_W-1:0] rd_mux;
    logic [31:0]       rise_ext;
    logic              pend_rd;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk        (clk),
            .rst        (rst),
            .raw        (raw_in[i]),
            .level      (level[i]),
            .rise_pulse (rise[i])
        );
    end

    assign pend_rd = rd_en && (rd_addr == ADDR_PEND);

    always_comb begin
        rise_ext           = '0;
        rise_ext[N_IN-1:0] = rise;
        rd_mux             = '0;
        case (rd_addr)
            ADDR_LEVEL: rd_mux[N_IN-1:0] = level;
            ADDR_PEND:  rd_mux[N_IN-1:0] = pend;
            ADDR_COUNT: rd_mux           = press_cnt;
            default:    rd_mux           = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            press_cnt <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            // A rise in the same cycle as the clearing read survives.
            pend      <= (pend_rd ? '0 : pend) | rise;
            press_cnt <= press_cnt + DATA_W'(popcount32(rise_ext));
            rd_valid  <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

`ifdef BOARD_INPUT_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend;
        end
    end
`endif

endmodule

// File: tb/tb_board_input_reader.sv
// Randomized + directed bench for board_input_reader (N_IN=4, DEBOUNCE_CYCLES=4)
// with a behavioural model: an input is accepted after the synchronized value
// has disagreed with the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module tb_board_input_reader;

    localparam int N  = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] raw_in;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
`ifdef BOARD_INPUT_IRQ_EN
    logic        irq;
`endif

    board_input_reader #(.N_IN(N), .DEBOUNCE_CYCLES(DC)) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`ifdef BOARD_INPUT_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [N-1:0] m_s1, m_s2, m_lvl, m_pend;
    int           m_run [N];
    logic [31:0]  m_cnt, m_rdata;
    logic         m_rvalid, m_irq;
    logic [N-1:0] cur_raw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0;
        m_cnt = '0; m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] rise, nl;
        if (rst) begin
            model_reset();
        end else begin
            rise = '0;
            nl   = m_lvl;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    if (m_run[i] + 1 >= DC) begin
                        nl[i]    = m_s2[i];
                        rise[i]  = m_s2[i];
                        m_run[i] = 0;
                    end else begin
                        m_run[i] = m_run[i] + 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rvalid = rd_en;
            if (rd_en) begin
                case (rd_addr)
                    2'd0: m_rdata = {28'd0, m_lvl};
                    2'd1: m_rdata = {28'd0, m_pend};
                    2'd2: m_rdata = m_cnt;
                    default: m_rdata = 32'd0;
                endcase
            end
            m_irq = |m_pend;
            if (rd_en && rd_addr == 2'd1) m_pend = '0;
            m_pend = m_pend | rise;
            m_cnt  = m_cnt + 32'($countones(rise));
            m_s2   = m_s1;
            m_s1   = raw_in;
            m_lvl  = nl;
        end
    endtask

    // One clock: drive, update model on the edge, compare on the falling edge.
    task automatic step(input logic [N-1:0] r, input logic rs, input logic re, input logic [1:0] a);
        raw_in = r; rst = rs; rd_en = re; rd_addr = a;
        cur_raw = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rvalid});
        chk("rd_data", rd_data, m_rdata);
`ifdef BOARD_INPUT_IRQ_EN
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    task automatic idle(input logic [N-1:0] r, input int n);
        for (int k = 0; k < n; k++) step(r, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        step(cur_raw, 1'b0, 1'b1, a);
        chk(name, rd_data, exp);
    endtask

    task automatic do_reset();
        step('0, 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        model_reset();
        cur_raw = '0;
        do_reset();
        chk("reset_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_data", rd_data, 32'd0);

        // short glitch never accepted
        idle(4'h1, 3);
        idle(4'h0, 10);
        rd(2'd0, 32'h0, "glitch_level");
        rd(2'd2, 32'h0, "glitch_count");

        // single held press
        do_reset();
        idle(4'h4, 10);
        rd(2'd0, 32'h4, "hold_level");
        rd(2'd1, 32'h4, "hold_pend");
        rd(2'd1, 32'h0, "hold_pend_cleared");
        rd(2'd2, 32'h1, "hold_count");
        rd(2'd3, 32'h0, "addr3_zero");

        // two bits rise together
        do_reset();
        idle(4'h3, 10);
        rd(2'd2, 32'h2, "dual_count");
        rd(2'd1, 32'h3, "dual_pend");

        // clearing read coincides with bit 3 acceptance: event wins
        do_reset();
        idle(4'h8, 5);
        rd(2'd1, 32'h0, "race_old_flags");
        rd(2'd1, 32'h8, "race_event_wins");

        // press counter wrap
        do_reset();
        force dut.press_cnt = 32'hFFFF_FFFF;
        #1 release dut.press_cnt;
        m_cnt = 32'hFFFF_FFFF;
        rd(2'd2, 32'hFFFF_FFFF, "preload_count");
        idle(4'h2, 10);
        rd(2'd2, 32'h0, "wrap_count");

        // reset mid-debounce with a read pending
        do_reset();
        idle(4'hF, 4);
        step(4'hF, 1'b1, 1'b1, 2'd2);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        idle(4'hF, 3);
        rd(2'd0, 32'h0, "rst_partial_discarded");
        idle(4'hF, 6);
`ifdef BOARD_INPUT_IRQ_EN
        chk("irq_high", {31'd0, irq}, 32'd1);
`endif
        rd(2'd2, 32'h4, "rst_held_presses");
        rd(2'd1, 32'hF, "rst_held_pend");
        step(4'hF, 1'b0, 1'b0, 2'd0);
`ifdef BOARD_INPUT_IRQ_EN
        chk("irq_low", {31'd0, irq}, 32'd0);
`endif

        // randomized traffic: sparse toggles give both glitches and stable runs
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] r;
            r = cur_raw;
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            step(r, ($urandom_range(149) == 0), ($urandom_range(2) == 0),
                 2'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
